// File: rtl/bus_host_arbiter.sv
// rtl/bus_host_arbiter.sv - round-robin host arbiter with in-order response routing
//
// Lets NrHosts bus hosts share one device-side port. One request is granted per
// cycle. The ID of every granted host is queued in an in-order FIFO so that each
// device response is routed back to the host that issued it.
//
// Optional feature macro: BUS_ARB_TIMEOUT_EN (response watchdog of TimeoutCycles).
//
// Ports:
//   clk_i, rst_i       clock, asynchronous active-high reset
//   host_req_i         per-host request
//   host_gnt_o         per-host grant (one-hot or zero)
//   host_addr_i        packed host addresses, host h at [h*AW +: AW]
//   host_we_i          per-host write enable
//   host_be_i          packed per-host byte enables (4 bits each)
//   host_wdata_i       packed per-host write data
//   host_rvalid_o      per-host response valid (one-hot or zero)
//   host_rdata_o       shared response data, qualified by host_rvalid_o
//   host_err_o         per-host response error
//   dev_req_o          device-side request
//   dev_gnt_i          device-side grant
//   dev_addr_o         address of the arbitration winner
//   dev_we_o           write enable of the arbitration winner
//   dev_be_o           byte enables of the arbitration winner
//   dev_wdata_o        write data of the arbitration winner
//   dev_rvalid_i       device response valid
//   dev_rdata_i        device response data
//   dev_err_i          device response error
//   busy_o             at least one transaction outstanding
module bus_host_arbiter #(
    parameter int unsigned NrHosts        = 2,
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned AddressWidth   = 32,
    parameter int unsigned MaxOutstanding = 4,
    parameter int unsigned TimeoutCycles  = 1024
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [NrHosts-1:0]              host_req_i,
    output logic [NrHosts-1:0]              host_gnt_o,
    input  logic [NrHosts*AddressWidth-1:0] host_addr_i,
    input  logic [NrHosts-1:0]              host_we_i,
    input  logic [NrHosts*4-1:0]            host_be_i,
    input  logic [NrHosts*DataWidth-1:0]    host_wdata_i,
    output logic [NrHosts-1:0]              host_rvalid_o,
    output logic [DataWidth-1:0]            host_rdata_o,
    output logic [NrHosts-1:0]              host_err_o,
    output logic                            dev_req_o,
    input  logic                            dev_gnt_i,
    output logic [AddressWidth-1:0]         dev_addr_o,
    output logic                            dev_we_o,
    output logic [3:0]                      dev_be_o,
    output logic [DataWidth-1:0]            dev_wdata_o,
    input  logic                            dev_rvalid_i,
    input  logic [DataWidth-1:0]            dev_rdata_i,
    input  logic                            dev_err_i,
    output logic                            busy_o
);

    localparam int unsigned IdW  = $clog2(NrHosts);
    localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int unsigned CntW = $clog2(MaxOutstanding) + 1;

    if (NrHosts < 2 || NrHosts > 8 || MaxOutstanding < 1 ||
        ((MaxOutstanding & (MaxOutstanding - 1)) != 0) || TimeoutCycles < 1) begin : g_param_check
        $error("bus_host_arbiter: illegal parameter set");
    end

    logic [IdW-1:0]  rr_q, rr_d;
    logic [IdW-1:0]  fifo_q [MaxOutstanding];
    logic [PtrW-1:0] wptr_q, wptr_d;
    logic [PtrW-1:0] rptr_q, rptr_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic           any_req;
    logic [IdW-1:0] winner;
    logic [IdW-1:0] cand;
    logic [IdW:0]   cand_sum;
    logic           empty, full;
    logic           push, pop, pop_dev, tmo_fire;
    logic [IdW-1:0] head;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == CntW'(MaxOutstanding));
    assign head    = fifo_q[rptr_q];
    assign pop_dev = ~empty & dev_rvalid_i;
    assign pop     = ~empty & (dev_rvalid_i | tmo_fire);
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign dev_req_o = any_req & ~rst_i & (~full | pop);
    assign push      = dev_req_o & dev_gnt_i;
    assign busy_o    = ~empty;

    // Round-robin search starting at the pointer, wrapping modulo NrHosts.
    always_comb begin
        any_req  = 1'b0;
        winner   = '0;
        cand     = '0;
        cand_sum = '0;
        for (int unsigned i = 0; i < NrHosts; i++) begin
            cand_sum = {1'b0, rr_q} + (IdW+1)'(i);
            if (cand_sum >= (IdW+1)'(NrHosts)) begin
                cand_sum = cand_sum - (IdW+1)'(NrHosts);
            end
            cand = cand_sum[IdW-1:0];
            if (!any_req && host_req_i[cand]) begin
                any_req = 1'b1;
                winner  = cand;
            end
        end
    end

    always_comb begin
        dev_addr_o  = '0;
        dev_we_o    = 1'b0;
        dev_be_o    = '0;
        dev_wdata_o = '0;
        for (int unsigned h = 0; h < NrHosts; h++) begin
            if (any_req && winner == IdW'(h)) begin
                dev_addr_o  = host_addr_i[h*AddressWidth +: AddressWidth];
                dev_we_o    = host_we_i[h];
                dev_be_o    = host_be_i[h*4 +: 4];
                dev_wdata_o = host_wdata_i[h*DataWidth +: DataWidth];
            end
        end
    end

    always_comb begin
        host_gnt_o    = '0;
        host_rvalid_o = '0;
        host_err_o    = '0;
        host_rdata_o  = '0;
        if (push) begin
            host_gnt_o[winner] = 1'b1;
        end
        if (pop) begin
            host_rvalid_o[head] = 1'b1;
            host_err_o[head]    = tmo_fire | dev_err_i;
        end
        // Timeout responses carry zero data.
        if (pop_dev) begin
            host_rdata_o = dev_rdata_i;
        end
    end

    always_comb begin
        rr_d   = rr_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (push) begin
            rr_d   = (winner == IdW'(NrHosts - 1)) ? '0 : winner + 1'b1;
            wptr_d = (wptr_q == PtrW'(MaxOutstanding - 1)) ? '0 : wptr_q + 1'b1;
        end
        if (pop) begin
            rptr_d = (rptr_q == PtrW'(MaxOutstanding - 1)) ? '0 : rptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_q   <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            for (int unsigned k = 0; k < MaxOutstanding; k++) begin
                fifo_q[k] <= '0;
            end
        end else begin
            rr_q   <= rr_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            if (push) begin
                fifo_q[wptr_q] <= winner;
            end
        end
    end

`ifdef BUS_ARB_TIMEOUT_EN
    localparam int unsigned TmoW = $clog2(TimeoutCycles + 1);
    logic [TmoW-1:0] tmo_q, tmo_d;

    // Fires on the TimeoutCycles-th consecutive cycle without a response;
    // a real response in that cycle takes precedence.
    assign tmo_fire = ~empty & ~dev_rvalid_i & (tmo_q == TmoW'(TimeoutCycles - 1));

    always_comb begin
        tmo_d = tmo_q + 1'b1;
        if (empty || pop) begin
            tmo_d = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    assign tmo_fire = 1'b0;
`endif

endmodule

// File: tb/tb_bus_host_arbiter.sv
// tb/tb_bus_host_arbiter.sv - self-checking bench for bus_host_arbiter
module tb_bus_host_arbiter;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MO = 4;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  req = '0;
    logic [N-1:0]  gnt_o;
    logic [N*AW-1:0] addr = '0;
    logic [N-1:0]  we = '0;
    logic [N*4-1:0] be = '0;
    logic [N*DW-1:0] wdata = '0;
    logic [N-1:0]  rv_o;
    logic [DW-1:0] rdata_o;
    logic [N-1:0]  err_o;
    logic          dev_req;
    logic          dev_gnt = 1'b0;
    logic [AW-1:0] dev_addr;
    logic          dev_we;
    logic [3:0]    dev_be;
    logic [DW-1:0] dev_wdata;
    logic          dev_rvalid = 1'b0;
    logic [DW-1:0] dev_rdata = '0;
    logic          dev_err = 1'b0;
    logic          busy;

    int checks = 0;
    int errors = 0;

    bus_host_arbiter #(
        .NrHosts(N), .DataWidth(DW), .AddressWidth(AW),
        .MaxOutstanding(MO), .TimeoutCycles(TO)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .host_req_i(req), .host_gnt_o(gnt_o), .host_addr_i(addr),
        .host_we_i(we), .host_be_i(be), .host_wdata_i(wdata),
        .host_rvalid_o(rv_o), .host_rdata_o(rdata_o), .host_err_o(err_o),
        .dev_req_o(dev_req), .dev_gnt_i(dev_gnt), .dev_addr_o(dev_addr),
        .dev_we_o(dev_we), .dev_be_o(dev_be), .dev_wdata_o(dev_wdata),
        .dev_rvalid_i(dev_rvalid), .dev_rdata_i(dev_rdata), .dev_err_i(dev_err),
        .busy_o(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct { int cyc; int host; } gnt_ev_t;
    typedef struct { int cyc; logic [N-1:0] rv; logic [DW-1:0] rdata; logic [N-1:0] err; } rv_ev_t;
    gnt_ev_t gnt_log[$];
    rv_ev_t  rv_log[$];

    // Reference model: outstanding host IDs in a queue, RR pointer as an integer.
    int q[$];
    int rr = 0;
    int tcnt = 0;
    int cyc = 0;
    logic [N-1:0] last_gnt = '0;
    int win, head;
    bit m_empty, m_full, m_tmo, m_pop, m_hs;
    logic e_req, e_we;
    logic [N-1:0] e_gnt, e_rv, e_err;
    logic [AW-1:0] e_addr;
    logic [3:0] e_be;
    logic [DW-1:0] e_wdata, e_rdata;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            chk("rst_gnt", gnt_o, 0);
            chk("rst_rvalid", rv_o, 0);
            chk("rst_err", err_o, 0);
            chk("rst_rdata", rdata_o, 0);
            chk("rst_dev_req", dev_req, 0);
            chk("rst_busy", busy, 0);
            q.delete();
            rr = 0;
            tcnt = 0;
            last_gnt = '0;
        end else begin
            win = -1;
            for (int i = 0; i < N; i++) begin
                if (win < 0 && req[(rr + i) % N]) win = (rr + i) % N;
            end
            m_empty = (q.size() == 0);
            m_full  = (q.size() == MO);
`ifdef BUS_ARB_TIMEOUT_EN
            m_tmo = !m_empty && !dev_rvalid && (tcnt == TO - 1);
`else
            m_tmo = 1'b0;
`endif
            m_pop = !m_empty && (dev_rvalid || m_tmo);
            head  = m_empty ? 0 : q[0];
            e_req = (win >= 0) && (!m_full || m_pop);
            m_hs  = e_req && dev_gnt;
            e_gnt = '0;
            if (m_hs) e_gnt[win] = 1'b1;
            e_addr = '0; e_we = 1'b0; e_be = '0; e_wdata = '0;
            if (win >= 0) begin
                e_addr  = addr[win*AW +: AW];
                e_we    = we[win];
                e_be    = be[win*4 +: 4];
                e_wdata = wdata[win*DW +: DW];
            end
            e_rv = '0; e_err = '0; e_rdata = '0;
            if (m_pop) begin
                e_rv[head] = 1'b1;
                if (m_tmo || dev_err) e_err[head] = 1'b1;
                if (!m_tmo) e_rdata = dev_rdata;
            end
            chk("dev_req", dev_req, e_req);
            chk("host_gnt", gnt_o, e_gnt);
            chk("dev_addr", dev_addr, e_addr);
            chk("dev_we", dev_we, e_we);
            chk("dev_be", dev_be, e_be);
            chk("dev_wdata", dev_wdata, e_wdata);
            chk("host_rvalid", rv_o, e_rv);
            chk("host_err", err_o, e_err);
            chk("host_rdata", rdata_o, e_rdata);
            chk("busy", busy, !m_empty);
            if (m_hs) gnt_log.push_back('{cyc, win});
            if (m_pop) rv_log.push_back('{cyc, e_rv, e_rdata, e_err});
            last_gnt = e_gnt;
            if (m_pop) void'(q.pop_front());
            if (m_hs) begin
                q.push_back(win);
                rr = (win + 1) % N;
            end
            if (m_empty || m_pop) tcnt = 0;
            else tcnt++;
        end
    end

    int rv_prob;

    initial begin
        repeat (2) step();
        #3;
        chk("reset_gnt_lit", gnt_o, 0);
        chk("reset_busy_lit", busy, 0);
        chk("reset_req_lit", dev_req, 0);
        step();
        rst = 1'b0;

        // Both hosts request, device always ready: grants alternate.
        gnt_log.delete();
        addr = {32'h0000_2000, 32'h0000_1000};
        req = 2'b11; dev_gnt = 1'b1; dev_rvalid = 1'b1;
        #3 chk("t1_addr_h0", dev_addr, 32'h1000);
        step();
        #3 chk("t1_addr_h1", dev_addr, 32'h2000);
        repeat (5) step();
        req = 2'b00;
        step();
        dev_rvalid = 1'b0;
        chk("t1_count", gnt_log.size(), 6);
        for (int k = 0; k < gnt_log.size() && k < 6; k++) chk("t1_order", gnt_log[k].host, k % 2);

        // Device stalls: no grant until dev_gnt rises.
        gnt_log.delete();
        req = 2'b10; dev_gnt = 1'b0;
        repeat (5) step();
        chk("t2_stall_none", gnt_log.size(), 0);
        dev_gnt = 1'b1;
        #3 chk("t2_gnt_h1", gnt_o, 2'b10);
        step();
        req = 2'b00; dev_rvalid = 1'b1;
        step();
        dev_rvalid = 1'b0;
        chk("t2_count", gnt_log.size(), 1);
        if (gnt_log.size() > 0) chk("t2_host", gnt_log[0].host, 1);

        // FIFO fills at MaxOutstanding; a response reopens it in the same cycle.
        gnt_log.delete();
        req = 2'b01; dev_gnt = 1'b1;
        repeat (5) step();
        #3;
        chk("t3_full_req", dev_req, 0);
        chk("t3_four_grants", gnt_log.size(), 4);
        step();
        dev_rvalid = 1'b1;
        #3;
        chk("t3_pop_req", dev_req, 1);
        chk("t3_fifth_gnt", gnt_o, 2'b01);
        step();
        req = 2'b00;
        repeat (4) step();
        dev_rvalid = 1'b0;
        #3 chk("t3_drained", busy, 0);

        // In-order response routing.
        rv_log.delete();
        step();
        req = 2'b01; we = 2'b00;
        step();
        req = 2'b10;
        step();
        req = 2'b01; we = 2'b01;
        step();
        req = 2'b00; we = 2'b00;
        dev_rvalid = 1'b1; dev_rdata = 32'hA; dev_err = 1'b0;
        step();
        dev_rdata = 32'hB;
        step();
        dev_rdata = 32'h0; dev_err = 1'b1;
        step();
        dev_rvalid = 1'b0; dev_err = 1'b0;
        chk("t4_count", rv_log.size(), 3);
        if (rv_log.size() == 3) begin
            chk("t4_rv0", rv_log[0].rv, 2'b01);
            chk("t4_rd0", rv_log[0].rdata, 32'hA);
            chk("t4_rv1", rv_log[1].rv, 2'b10);
            chk("t4_rd1", rv_log[1].rdata, 32'hB);
            chk("t4_rv2", rv_log[2].rv, 2'b01);
            chk("t4_err2", rv_log[2].err, 2'b01);
        end

        // Stray responses with nothing outstanding are dropped.
        rv_log.delete();
        dev_rvalid = 1'b1;
        repeat (3) step();
        dev_rvalid = 1'b0;
        #3;
        chk("t5_busy", busy, 0);
        chk("t5_no_rvalid", rv_log.size(), 0);

        // Randomized traffic; hosts hold request and payload until granted.
        for (int c = 0; c < 3000; c++) begin
            step();
            rv_prob = ((c / 400) % 2 == 1) ? 4 : 45;
            for (int h = 0; h < N; h++) begin
                if (!req[h] || last_gnt[h]) begin
                    req[h] = ($urandom % 100) < 60;
                    addr[h*AW +: AW] = $urandom;
                    we[h] = $urandom % 2;
                    be[h*4 +: 4] = $urandom % 16;
                    wdata[h*DW +: DW] = $urandom;
                end
            end
            dev_gnt    = ($urandom % 100) < 70;
            dev_rvalid = ($urandom % 100) < rv_prob;
            dev_rdata  = $urandom;
            dev_err    = ($urandom % 4) == 0;
            if (c == 1500) rst = 1'b1;
            if (c == 1503) rst = 1'b0;
        end

        // Single grant with no response.
        req = '0; dev_rvalid = 1'b0; dev_err = 1'b0;
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        gnt_log.delete();
        rv_log.delete();
        req = 2'b10; dev_gnt = 1'b1;
        step();
        req = 2'b00;
        repeat (25) step();
        #3;
        chk("t6_grants", gnt_log.size(), 1);
`ifdef BUS_ARB_TIMEOUT_EN
        chk("t6_tmo_count", rv_log.size(), 1);
        if (rv_log.size() > 0 && gnt_log.size() > 0) begin
            chk("t6_tmo_rv", rv_log[0].rv, 2'b10);
            chk("t6_tmo_err", rv_log[0].err, 2'b10);
            chk("t6_tmo_rdata", rv_log[0].rdata, 0);
            chk("t6_tmo_delay", rv_log[0].cyc - gnt_log[0].cyc, 16);
        end
        chk("t6_busy", busy, 0);
`else
        chk("t6_no_response", rv_log.size(), 0);
        chk("t6_busy", busy, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
